fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the LC-3-style pipeline. Holds the program counter, drives a word address into the combinational instruction memory, and buffers fetched words in a 2-entry queue, each tagged with its PC, toward decode through a valid/ready handshake. Stops fetching after a HALT word and restarts on a redirect from the branch/execute stage.

## Interface
- `ADDR_W`, 32, PC and memory address width (word index, not byte)
- `DATA_W`, 32, instruction width
- `RESET_PC`, 0, PC value after reset
- `HALT_OPC`, 4'h6, value of `instr[31:28]` that denotes HALT

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_addr`  out  ADDR_W  address to instruction memory; equals PC register
- `imem_instr`  in  DATA_W  combinational read data for `imem_addr`
- `out_valid`  out  1  head entry valid toward decode
- `out_ready`  in  1  decode accepts head this cycle
- `out_instr`  out  DATA_W  head instruction
- `out_pc`  out  ADDR_W  address the head instruction was fetched from
- `redirect_valid`  in  1  branch taken / restart request
- `redirect_pc`  in  ADDR_W  new PC
- `halted`  out  1  fetch stopped on HALT

## Operation
- Clock and reset: one clock `clk`; `rst_n` is asynchronous and active-low.
- Queue: 2 entries {instr, pc}, with a count of 0 to 2. Head drives `out_*` directly from registers.
- pop = `out_valid & out_ready`.
- fetch = `!halted & !redirect_valid & (count<2 | pop)`.
- On fetch:
  - `imem_instr` and the PC are written at the tail.
  - PC advances to PC+1, modulo 2^ADDR_W; 0xFFFF_FFFF wraps to 0.
- Push and pop in the same cycle are allowed at any count. The count is unchanged and order is preserved.
- HALT:
  - If the fetched word has `[31:28]==HALT_OPC`, it is still enqueued.
  - `halted` sets on that same edge. The PC is not advanced past the HALT word.
  - Words already queued continue to drain normally.
- Redirect, when `redirect_valid` is high at an edge:
  - The queue is flushed to count 0, including any pop that edge.
  - PC is loaded from `redirect_pc` and `halted` is cleared. No fetch occurs that cycle.
  - Redirect has priority over fetch, pop and HALT detection.
- `out_valid` = count != 0.
- When the queue is empty, `out_instr` and `out_pc` hold their last values. They are don't-care to decode.

## Timing
- Reset values: PC=`RESET_PC`, count=0, `out_valid`=0, `out_instr`=0, `out_pc`=0, `halted`=0.
- `imem_addr` tracks PC with zero latency. Memory read is combinational within the cycle.
- Latency: a word fetched at edge N is visible on `out_*` after edge N if the queue was empty.
- Steady state with `out_ready`=1: 1 instruction per cycle.
- Backpressure:
  - With `out_ready`=0, two words fill the queue and fetch stops.
  - PC then holds at the next unfetched address.
- Head stability: while `out_valid`=1 and `out_ready`=0, `out_instr` and `out_pc` must stay stable.
- Redirect: the first redirected word appears on `out_*` 2 edges after `redirect_valid` is sampled (flush edge, then fetch edge).
- Reset asserted mid-operation: all state returns to reset values immediately. Queue contents are discarded.

## Structure
- Shared package `lc3_pkg` holds:
  - the opcode constants (`OPC_ADD`=2, `OPC_LD`=3, `OPC_ST`=4, `OPC_BEQ`=5, `OPC_HALT`=6)
  - `ADDR_W` and `DATA_W` defaults
  - a `fetch_entry_t` {instr, pc} struct
- One sub-module: `fetch_queue`, a 2-entry synchronous FIFO with push, pop and flush. It is parameterised on entry width.
- PC, HALT detection and redirect logic live in `fetch_stage`.

## Test plan
- Reset, then `out_ready`=1, with memory[0..7] = 22000001, 22000017, 40020003, 34000003, 50000002, 34000003, 25200017, 60000004.
  - `out_instr` sequence is 22000001 through 60000004, with `out_pc` 0..7, one per cycle.
  - `halted`=1 after the 8th fetch; `imem_addr` stays at 7.
- Hold `out_ready`=0 for 5 cycles after reset.
  - Count saturates at 2 and PC=2.
  - Head stays 22000001/pc 0.
  - On release, words 0, 1, 2 are delivered in order.
- Simultaneous push and pop at count=2 is exercised by toggling `out_ready` every cycle. There must be no loss or duplication over 100 random cycles, checked against a reference model.
- After HALT, assert `redirect_valid` with `redirect_pc`=3.
  - `halted` clears and the queue is flushed.
  - `out_pc`=3 appears 2 edges later with `out_instr`=34000003.
- Set `redirect_valid` while the queue is full and `out_ready`=1. The popped word is dropped, count=0, and there is no fetch that cycle.
- Start with PC=0xFFFF_FFFF via redirect. The next `out_pc` values are FFFF_FFFF then 0.
- Pulse `rst_n` low mid-stream. All outputs go to reset values asynchronously, and fetch resumes from `RESET_PC`.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3-style pipeline: default widths, opcode
// encodings of instr[31:28], and the fetch queue entry layout.
package lc3_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [3:0] OPC_ADD  = 4'h2;
  localparam logic [3:0] OPC_LD   = 4'h3;
  localparam logic [3:0] OPC_ST   = 4'h4;
  localparam logic [3:0] OPC_BEQ  = 4'h5;
  localparam logic [3:0] OPC_HALT = 4'h6;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO with push, pop and flush. The head slot is a
// register so downstream sees it directly; flush drops contents but keeps data.
module fetch_queue
  import lc3_pkg::*;
#(
  parameter int W = FETCH_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;

  assign do_pop    = pop && (count_q != 2'd0);
  assign head_data = slot0_q;
  assign count     = count_q;

  // slot0 is always the head; slot1 only holds the second entry when count is 2.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            slot0_d = push_data;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && do_pop) begin
            slot0_d = push_data;
          end else if (push) begin
            slot1_d = push_data;
            count_d = 2'd2;
          end else if (do_pop) begin
            count_d = 2'd0;
          end
        end
        default: begin
          if (do_pop) begin
            slot0_d = slot1_q;
            count_d = 2'd1;
            if (push) begin
              slot1_d = push_data;
              count_d = 2'd2;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  property p_no_overflow;
    @(posedge clk) disable iff (!rst_n)
      !(push && !flush && (count_q == 2'd2) && !do_pop);
  endproperty
  a_no_overflow: assert property (p_no_overflow);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, HALT stop, redirect restart, and a 2-entry
// {instr, pc} queue toward decode.
// Handshake: a head word transfers on any edge where out_valid && out_ready;
// out_valid never depends on out_ready, and the head holds while not accepted.
module fetch_stage
  import lc3_pkg::*;
#(
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OPC = OPC_HALT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam int EW = DATA_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic [1:0]        q_count;
  logic [EW-1:0]     q_head;
  logic              pop;
  logic              fetch;
  logic              is_halt;

  assign out_valid = (q_count != 2'd0);
  assign out_instr = q_head[EW-1:ADDR_W];
  assign out_pc    = q_head[ADDR_W-1:0];
  assign imem_addr = pc_q;
  assign halted    = halted_q;

  assign pop     = out_valid && out_ready;
  assign is_halt = (imem_instr[DATA_W-1 -: 4] == HALT_OPC);
  // Redirect wins over everything, so it also gates fetch directly.
  assign fetch   = !halted_q && !redirect_valid && ((q_count != 2'd2) || pop);

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end else if (fetch) begin
      if (is_halt) begin
        halted_d = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_queue #(
    .W (EW)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fetch),
    .push_data ({imem_instr, pc_q}),
    .pop       (pop && !redirect_valid),
    .flush     (redirect_valid),
    .head_data (q_head),
    .count     (q_count)
  );

  property p_head_stable;
    @(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !redirect_valid) |=> ($stable(out_instr) && $stable(out_pc));
  endproperty
  a_head_stable: assert property (p_head_stable);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, directed corner sequences, and a random
// handshake run compared against a queue-based reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [8] = '{32'h22000001, 32'h22000017, 32'h40020003, 32'h34000003,
                            32'h50000002, 32'h34000003, 32'h25200017, 32'h60000004};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd8) return prog[a[2:0]];
    return {4'h2, a[27:0]};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state: queue of {instr, pc}, PC and halt flag
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_pc   = 32'd0;
    m_halt = 1'b0;
  endtask

  task automatic check_head(input string name, input logic [31:0] ei, input logic [31:0] ep);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_instr"}, out_instr, ei);
    check({name, "_pc"}, out_pc, ep);
  endtask

  // one edge of the reference model, applied with the inputs currently driven
  task automatic model_step();
    logic        pop;
    logic        fetch;
    logic [31:0] w;
    pop = (exp_q.size() != 0) && out_ready;
    if (redirect_valid) begin
      exp_q.delete();
      m_pc   = redirect_pc;
      m_halt = 1'b0;
    end else begin
      fetch = !m_halt && ((exp_q.size() < 2) || pop);
      if (pop) void'(exp_q.pop_front());
      if (fetch) begin
        w = mem_word(m_pc);
        exp_q.push_back({w, m_pc});
        if (w[31:28] == 4'h6) m_halt = 1'b1;
        else m_pc = m_pc + 32'd1;
      end
    end
  endtask

  task automatic compare_model(input int cyc);
    check($sformatf("rand_valid@%0d", cyc), 32'(out_valid), 32'(exp_q.size() != 0));
    check($sformatf("rand_halted@%0d", cyc), 32'(halted), 32'(m_halt));
    check($sformatf("rand_addr@%0d", cyc), imem_addr, m_pc);
    if (exp_q.size() != 0) begin
      check($sformatf("rand_instr@%0d", cyc), out_instr, exp_q[0][63:32]);
      check($sformatf("rand_pc@%0d", cyc), out_pc, exp_q[0][31:0]);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        eh;
    logic [31:0] ea;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'h22000001, 32'd0, 1'b0, 32'd1};
    vt[1]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'h22000017, 32'd1, 1'b0, 32'd2};
    vt[2]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'h40020003, 32'd2, 1'b0, 32'd3};
    vt[3]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'h34000003, 32'd3, 1'b0, 32'd4};
    vt[4]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'h50000002, 32'd4, 1'b0, 32'd5};
    vt[5]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'h34000003, 32'd5, 1'b0, 32'd6};
    vt[6]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'h25200017, 32'd6, 1'b0, 32'd7};
    vt[7]  = '{1'b1, 1'b0, 32'd0, 1'b1, 32'h60000004, 32'd7, 1'b1, 32'd7};
    vt[8]  = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0,        32'd0, 1'b1, 32'd7};
    vt[9]  = '{1'b1, 1'b1, 32'd3, 1'b0, 32'd0,        32'd0, 1'b0, 32'd3};
    vt[10] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'h34000003, 32'd3, 1'b0, 32'd4};
    vt[11] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'h50000002, 32'd4, 1'b0, 32'd5};

    // reset values, sampled while reset is held
    drive(1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    do_reset();

    // program run to HALT, then redirect to 3
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rdy, vt[i].rv, vt[i].rpc);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vt[i].eh));
      check($sformatf("vec%0d_addr", i), imem_addr, vt[i].ea);
      if (vt[i].ev) begin
        check($sformatf("vec%0d_instr", i), out_instr, vt[i].ei);
        check($sformatf("vec%0d_pc", i), out_pc, vt[i].ep);
      end
    end

    // backpressure: queue fills at 2, head and PC hold
    do_reset();
    drive(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_head($sformatf("bp_hold%0d", i), 32'h22000001, 32'd0);
    end
    check("bp_addr", imem_addr, 32'd2);
    drive(1'b1, 1'b0, 32'd0);
    tick();
    check_head("bp_rel0", 32'h22000017, 32'd1);
    tick();
    check_head("bp_rel1", 32'h40020003, 32'd2);
    tick();
    check_head("bp_rel2", 32'h34000003, 32'd3);

    // redirect while full and being popped: pop dropped, no fetch that cycle
    do_reset();
    drive(1'b0, 1'b0, 32'd0);
    tick();
    tick();
    check("full_addr", imem_addr, 32'd2);
    drive(1'b1, 1'b1, 32'd5);
    tick();
    check("fr_valid", 32'(out_valid), 32'd0);
    check("fr_addr", imem_addr, 32'd5);
    drive(1'b1, 1'b0, 32'd0);
    tick();
    check_head("fr_first", 32'h34000003, 32'd5);
    check("fr_addr2", imem_addr, 32'd6);

    // PC wrap from all-ones to zero
    do_reset();
    drive(1'b1, 1'b1, 32'hFFFF_FFFF);
    tick();
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 32'd0);
    tick();
    check_head("wrap_top", 32'h2FFF_FFFF, 32'hFFFF_FFFF);
    check("wrap_addr1", imem_addr, 32'd0);
    tick();
    check_head("wrap_zero", 32'h22000001, 32'd0);

    // asynchronous reset mid-stream
    do_reset();
    drive(1'b1, 1'b0, 32'd0);
    repeat (3) tick();
    check_head("ar_pre", 32'h40020003, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_instr", out_instr, 32'd0);
    check("ar_pc", out_pc, 32'd0);
    check("ar_halted", 32'(halted), 32'd0);
    check("ar_addr", imem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_head("ar_resume", 32'h22000001, 32'd0);

    // random handshake toggling with occasional redirects
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'((i % 2) ^ ($urandom_range(0, 7) == 0)),
            1'($urandom_range(0, 15) == 0),
            32'($urandom_range(0, 9)));
      compare_model(i);
      model_step();
      tick();
    end
    compare_model(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
